// File: rtl/rice_core_id_stage.sv
// Decode stage: latches one fetched instruction, extracts fields and immediate,
// reads operands with writeback bypass and keeps held operands coherent.
module rice_core_id_stage #(
   parameter int XLEN = 32
) (
   input  logic                       i_clk,
   input  logic                       i_rst_n,
   input  logic                       i_flush,
   input  logic                       i_if_valid,
   output logic                       o_if_ready,
   input  logic [XLEN-1:0]            i_if_pc,
   input  logic [31:0]                i_if_inst,
   input  logic [31:0][XLEN-1:0]      i_rf_value,
   input  logic                       i_wb_valid,
   input  logic [4:0]                 i_wb_rd,
   input  logic [XLEN-1:0]            i_wb_value,
   output logic                       o_id_valid,
   input  logic                       i_ex_ready,
   output logic [XLEN-1:0]            o_id_pc,
   output logic [31:0]                o_id_inst,
   output logic [4:0]                 o_id_rd,
   output logic [4:0]                 o_id_rs1,
   output logic [4:0]                 o_id_rs2,
   output logic [XLEN-1:0]            o_id_rs1_value,
   output logic [XLEN-1:0]            o_id_rs2_value,
   output logic [XLEN-1:0]            o_id_imm,
   output logic                       o_id_illegal
);

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_REG    = 7'b0110011;
   localparam logic [6:0] OP_FENCE  = 7'b0001111;

   logic                  id_valid;
   logic [XLEN-1:0]       id_pc;
   logic [31:0]           id_inst;
   logic [XLEN-1:0]       id_imm;
   logic                  id_illegal;
   logic [1:0][XLEN-1:0]  held_val;

   logic                  capture;
   logic signed [31:0]    dec_imm32;
   logic                  dec_illegal;
   logic [1:0][4:0]       src_new;
   logic [1:0][4:0]       src_held;
   logic [1:0][XLEN-1:0]  cap_val;
   logic [1:0]            hit_held;

   assign o_if_ready = !id_valid || i_ex_ready || i_flush;
   assign capture    = i_if_valid && o_if_ready && !i_flush;

   assign src_new  = {i_if_inst[24:20], i_if_inst[19:15]};
   assign src_held = {id_inst[24:20], id_inst[19:15]};

   always_comb begin
      dec_imm32   = '0;
      dec_illegal = 1'b0;
      unique case (i_if_inst[6:0])
         OP_LOAD, OP_IMM, OP_JALR, OP_SYSTEM:
            dec_imm32 = {{20{i_if_inst[31]}}, i_if_inst[31:20]};
         OP_STORE:
            dec_imm32 = {{20{i_if_inst[31]}}, i_if_inst[31:25], i_if_inst[11:7]};
         OP_BRANCH:
            dec_imm32 = {{19{i_if_inst[31]}}, i_if_inst[31], i_if_inst[7],
                         i_if_inst[30:25], i_if_inst[11:8], 1'b0};
         OP_LUI, OP_AUIPC:
            dec_imm32 = {i_if_inst[31:12], 12'b0};
         OP_JAL:
            dec_imm32 = {{11{i_if_inst[31]}}, i_if_inst[31], i_if_inst[19:12],
                         i_if_inst[20], i_if_inst[30:21], 1'b0};
         OP_REG, OP_FENCE:
            dec_imm32 = '0;
         default:
            dec_illegal = 1'b1;
      endcase
   end

   // x0 is forced to zero rather than trusting the register file view
   always_comb begin
      for (int s = 0; s < 2; s++) begin
         if (src_new[s] == 5'd0)
            cap_val[s] = '0;
         else if (i_wb_valid && i_wb_rd == src_new[s])
            cap_val[s] = i_wb_value;
         else
            cap_val[s] = i_rf_value[src_new[s]];
         hit_held[s] = i_wb_valid && (i_wb_rd == src_held[s]) && (src_held[s] != 5'd0);
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         id_valid   <= 1'b0;
         id_pc      <= '0;
         id_inst    <= '0;
         id_imm     <= '0;
         id_illegal <= 1'b0;
         held_val   <= '0;
      end else if (i_flush) begin
         id_valid <= 1'b0;
      end else if (capture) begin
         id_valid   <= 1'b1;
         id_pc      <= i_if_pc;
         id_inst    <= i_if_inst;
         id_imm     <= XLEN'(dec_imm32);
         id_illegal <= dec_illegal;
         held_val   <= cap_val;
      end else if (id_valid) begin
         if (i_ex_ready)
            id_valid <= 1'b0;
         for (int s = 0; s < 2; s++)
            if (hit_held[s])
               held_val[s] <= i_wb_value;
      end
   end

   assign o_id_valid     = id_valid;
   assign o_id_pc        = id_pc;
   assign o_id_inst      = id_inst;
   assign o_id_rd        = id_inst[11:7];
   assign o_id_rs1       = src_held[0];
   assign o_id_rs2       = src_held[1];
   assign o_id_imm       = id_imm;
   assign o_id_illegal   = id_illegal;
   assign o_id_rs1_value = hit_held[0] ? i_wb_value : held_val[0];
   assign o_id_rs2_value = hit_held[1] ? i_wb_value : held_val[1];

endmodule

// File: tb/tb_rice_core_id_stage.sv
// Bench for rice_core_id_stage: architectural model compared every cycle,
// plus directed sequences with literal expectations.
module tb_rice_core_id_stage;
   localparam int XLEN = 32;

   logic                  clk = 1'b0;
   logic                  rst_n;
   logic                  flush, if_valid, if_ready, wb_valid, ex_ready;
   logic [XLEN-1:0]       if_pc, wb_value;
   logic [31:0]           if_inst;
   logic [4:0]            wb_rd;
   logic [31:0][XLEN-1:0] rfv;
   logic                  id_valid, id_illegal;
   logic [XLEN-1:0]       id_pc, id_rs1_value, id_rs2_value, id_imm;
   logic [31:0]           id_inst;
   logic [4:0]            id_rd, id_rs1, id_rs2;

   int checks = 0;
   int errors = 0;

   logic [XLEN-1:0] rf [32];
   logic            m_valid;
   logic [XLEN-1:0] m_pc;
   logic [31:0]     m_inst;

   always #5 clk = ~clk;

   rice_core_id_stage #(.XLEN(XLEN)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush),
      .i_if_valid(if_valid), .o_if_ready(if_ready),
      .i_if_pc(if_pc), .i_if_inst(if_inst), .i_rf_value(rfv),
      .i_wb_valid(wb_valid), .i_wb_rd(wb_rd), .i_wb_value(wb_value),
      .o_id_valid(id_valid), .i_ex_ready(ex_ready),
      .o_id_pc(id_pc), .o_id_inst(id_inst), .o_id_rd(id_rd),
      .o_id_rs1(id_rs1), .o_id_rs2(id_rs2),
      .o_id_rs1_value(id_rs1_value), .o_id_rs2_value(id_rs2_value),
      .o_id_imm(id_imm), .o_id_illegal(id_illegal)
   );

   always_comb begin
      for (int i = 0; i < 32; i++) rfv[i] = (i == 0) ? '0 : rf[i];
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%0h exp=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic longint sext(input longint v, input int n);
      return (v >= (64'sd1 <<< (n - 1))) ? v - (64'sd1 <<< n) : v;
   endfunction

   // Immediate built from the instruction-set bit layouts with plain arithmetic
   function automatic logic [31:0] exp_imm(input logic [31:0] w);
      longint u = longint'(w);
      longint v;
      case (u & 127)
         3, 19, 103, 115: v = sext(u >> 20, 12);
         35:  v = sext(((u >> 25) << 5) + ((u >> 7) & 31), 12);
         99:  v = sext((((u >> 31) & 1) << 12) + (((u >> 7) & 1) << 11)
                       + (((u >> 25) & 63) << 5) + (((u >> 8) & 15) << 1), 13);
         55, 23: v = sext(u & 64'hFFFFF000, 32);
         111: v = sext((((u >> 31) & 1) << 20) + (((u >> 12) & 255) << 12)
                       + (((u >> 20) & 1) << 11) + (((u >> 21) & 1023) << 1), 21);
         default: v = 0;
      endcase
      return v[31:0];
   endfunction

   function automatic logic exp_ill(input logic [31:0] w);
      int op = int'(w[6:0]);
      return !(op == 3 || op == 19 || op == 103 || op == 115 || op == 35 || op == 99 ||
               op == 55 || op == 23 || op == 111 || op == 51 || op == 15);
   endfunction

   // Operand as the architecture sees it right now, including the writeback in flight
   function automatic logic [XLEN-1:0] exp_src(input logic [4:0] s);
      if (s == 0) return '0;
      if (wb_valid && wb_rd == s) return wb_value;
      return rf[s];
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_valid = 1'b0;
         for (int i = 0; i < 32; i++) rf[i] <= '0;
      end else begin
         if (flush) m_valid = 1'b0;
         else if (if_valid && (!m_valid || ex_ready)) begin
            m_valid = 1'b1;
            m_pc    = if_pc;
            m_inst  = if_inst;
         end else if (ex_ready) m_valid = 1'b0;
         if (wb_valid && wb_rd != 0) rf[wb_rd] <= wb_value;
      end
   end

   always @(negedge clk) begin
      chk("m_valid", 64'(id_valid), 64'(m_valid));
      chk("m_ready", 64'(if_ready), 64'(!m_valid || ex_ready || flush));
      if (m_valid) begin
         chk("m_pc", 64'(id_pc), 64'(m_pc));
         chk("m_inst", 64'(id_inst), 64'(m_inst));
         chk("m_rd", 64'(id_rd), 64'(m_inst[11:7]));
         chk("m_rs1", 64'(id_rs1), 64'(m_inst[19:15]));
         chk("m_rs2", 64'(id_rs2), 64'(m_inst[24:20]));
         chk("m_imm", 64'(id_imm), 64'(exp_imm(m_inst)));
         chk("m_illegal", 64'(id_illegal), 64'(exp_ill(m_inst)));
         chk("m_rs1_value", 64'(id_rs1_value), 64'(exp_src(m_inst[19:15])));
         chk("m_rs2_value", 64'(id_rs2_value), 64'(exp_src(m_inst[24:20])));
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   logic [31:0] tab_inst [4] = '{32'hFE000EE3, 32'h0080006F, 32'h12345037, 32'h0000007F};
   logic [31:0] tab_imm  [4] = '{32'hFFFFFFFC, 32'h00000008, 32'h12345000, 32'h00000000};
   logic        tab_ill  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};

   initial begin
      rst_n = 0; flush = 0; if_valid = 0; ex_ready = 0; wb_valid = 0;
      wb_rd = 0; wb_value = 0; if_pc = 0; if_inst = 0;
      #12 rst_n = 1;
      #1;
      chk("rst_valid", 64'(id_valid), 0);
      chk("rst_pc", 64'(id_pc), 0);
      chk("rst_inst", 64'(id_inst), 0);
      chk("rst_imm", 64'(id_imm), 0);
      chk("rst_ops", 64'({id_rs1_value, id_rs2_value}), 0);
      chk("rst_illegal", 64'(id_illegal), 0);
      chk("rst_ready", 64'(if_ready), 1);
      step();

      // addi x1,x0,5 while x3 is loaded with 0x11 by writeback
      if_valid = 1; if_pc = 32'h100; if_inst = 32'h00500093; ex_ready = 1;
      wb_valid = 1; wb_rd = 3; wb_value = 32'h11;
      step();
      chk("addi_valid", 64'(id_valid), 1);
      chk("addi_rd", 64'(id_rd), 1);
      chk("addi_rs1", 64'(id_rs1), 0);
      chk("addi_imm", 64'(id_imm), 5);
      chk("addi_pc", 64'(id_pc), 32'h100);
      chk("addi_illegal", 64'(id_illegal), 0);
      if_valid = 0; wb_rd = 0; wb_value = 32'h55;
      #1 chk("addi_x0_no_bypass", 64'(id_rs1_value), 0);
      step();
      wb_valid = 0;
      chk("addi_drain", 64'(id_valid), 0);

      // add x4,x3,x3 captured in the same cycle x3 is rewritten
      if_valid = 1; if_pc = 32'h104; if_inst = 32'h00318233;
      wb_valid = 1; wb_rd = 3; wb_value = 32'h22;
      step();
      wb_valid = 0; if_valid = 0; ex_ready = 0;
      #1;
      chk("add_rs1_value", 64'(id_rs1_value), 32'h22);
      chk("add_rs2_value", 64'(id_rs2_value), 32'h22);
      chk("add_rd", 64'(id_rd), 4);
      ex_ready = 1;
      step();

      // sw x5,-4(x2) stalled three cycles, x5 written in the second
      if_valid = 1; if_pc = 32'h108; if_inst = 32'hFE512E23;
      step();
      ex_ready = 0; if_pc = 32'h200; if_inst = 32'h00000013;
      #1 chk("sw_ready_c1", 64'(if_ready), 0);
      step();
      wb_valid = 1; wb_rd = 5; wb_value = 32'hDEAD;
      #1 chk("sw_bypass_c2", 64'(id_rs2_value), 32'hDEAD);
      chk("sw_ready_c2", 64'(if_ready), 0);
      step();
      wb_valid = 0;
      #1;
      chk("sw_refresh_c3", 64'(id_rs2_value), 32'hDEAD);
      chk("sw_imm", 64'(id_imm), 32'hFFFFFFFC);
      chk("sw_pc", 64'(id_pc), 32'h108);
      chk("sw_ready_c3", 64'(if_ready), 0);
      step();

      // flush while stalled with a beat presented
      flush = 1;
      #1 chk("flush_ready", 64'(if_ready), 1);
      step();
      flush = 0; if_valid = 0;
      #1 chk("flush_valid", 64'(id_valid), 0);
      step();
      chk("flush_dropped", 64'(id_valid), 0);

      // four back-to-back beats covering B/J/U/illegal immediates
      ex_ready = 1; if_valid = 1;
      for (int i = 0; i < 4; i++) begin
         if_pc = 32'h300 + 32'(4 * i); if_inst = tab_inst[i];
         step();
         chk("b2b_valid", 64'(id_valid), 1);
         chk("b2b_inst", 64'(id_inst), 64'(tab_inst[i]));
         chk("b2b_imm", 64'(id_imm), 64'(tab_imm[i]));
         chk("b2b_illegal", 64'(id_illegal), 64'(tab_ill[i]));
      end
      if_valid = 0;
      step();
      chk("b2b_drain", 64'(id_valid), 0);

      // asynchronous reset mid-stall
      if_valid = 1; if_pc = 32'h400; if_inst = 32'h00500093;
      step();
      if_valid = 0; ex_ready = 0;
      step();
      chk("stall_before_rst", 64'(id_valid), 1);
      #2 rst_n = 0;
      #1;
      chk("async_rst_valid", 64'(id_valid), 0);
      chk("async_rst_pc", 64'(id_pc), 0);
      #3 rst_n = 1;
      step();
      chk("after_rst_valid", 64'(id_valid), 0);
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/rice_core_id_stage.md
# rice_core_id_stage

Instruction-decode stage between instruction fetch and execute. It does four things:
- Accepts one fetched instruction per cycle through a valid/ready handshake.
- Extracts rs1/rs2/rd and the format-specific immediate.
- Reads source operands from the architectural register file, bypassing the writeback currently being presented to the register file.
- Holds the decoded instruction in a pipeline register until execute accepts it, keeping held operands coherent with writebacks that land while it waits.

## Interface
Parameters:
- XLEN, 32, data/address width (32 or 64)

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_flush  in  1  discard held and incoming instruction
- i_if_valid  in  1  fetch presents an instruction
- o_if_ready  out  1  stage can accept the fetch beat
- i_if_pc  in  XLEN  PC of fetched instruction
- i_if_inst  in  32  fetched instruction word
- i_rf_value  in  32×XLEN  register file read view; entry 0 is always 0
- i_wb_valid  in  1  writeback valid (same signal that writes the register file)
- i_wb_rd  in  5  writeback destination
- i_wb_value  in  XLEN  writeback data
- o_id_valid  out  1  decoded instruction held
- i_ex_ready  in  1  execute accepts held instruction
- o_id_pc  out  XLEN  held PC
- o_id_inst  out  32  held instruction word
- o_id_rd  out  5  inst[11:7]
- o_id_rs1  out  5  inst[19:15]
- o_id_rs2  out  5  inst[24:20]
- o_id_rs1_value  out  XLEN  rs1 operand, bypassed
- o_id_rs2_value  out  XLEN  rs2 operand, bypassed
- o_id_imm  out  XLEN  sign-extended immediate
- o_id_illegal  out  1  opcode not in the supported set

## Operation
- Reset: o_id_valid=0. All other held registers reset to 0, so every data output reads 0.
- Acceptance: o_if_ready = !o_id_valid || i_ex_ready. Transfer in = i_if_valid && o_if_ready.
- Handoff: transfer out = o_id_valid && i_ex_ready.
- Edge update:
  - Transfer in → capture pc, inst, decoded fields, immediate, illegal and both operands; o_id_valid←1.
  - Otherwise, transfer out → o_id_valid←0.
  - Otherwise → hold.
- Operand capture, per source s (rs1, rs2):
  - value = (i_wb_valid && i_wb_rd==s && s!=0) ? i_wb_value : i_rf_value[s].
  - s==0 always yields 0.
- Held-operand refresh:
  - Applies when o_id_valid=1 and the stage does not capture a new instruction.
  - If i_wb_valid && i_wb_rd==held s && s!=0, the held value←i_wb_value.
- Output bypass, combinational:
  - o_id_rsN_value = (i_wb_valid && i_wb_rd==held s && s!=0) ? i_wb_value : held value.
  - Execute therefore sees a result written in the same cycle it accepts the instruction.
- Immediate by opcode inst[6:0]:
  - I-type (0000011, 0010011, 1100111, 1110011): sext(inst[31:20]).
  - S-type (0100011): sext({inst[31:25],inst[11:7]}).
  - B-type (1100011): sext({inst[31],inst[7],inst[30:25],inst[11:8],1'b0}).
  - U-type (0110111, 0010111): sext({inst[31:12],12'b0}).
  - J-type (1101111): sext({inst[31],inst[19:12],inst[20],inst[30:21],1'b0}).
  - R-type (0110011) and fence (0001111): 0.
  - Any other opcode: imm=0, illegal=1.
- Sign extension is to XLEN. For XLEN=64 the U-type value is sign-extended from bit 31.
- Flush:
  - i_flush=1 → o_if_ready=1 (the fetch beat is consumed and discarded).
  - o_id_valid←0 at the edge.
  - Flush has priority over capture and hold.
- Reset mid-operation: o_id_valid drops immediately (asynchronous). The held instruction is lost.

## Timing
- Latency: 1 cycle from accepted fetch beat to o_id_valid.
- Throughput: 1 instruction/cycle while i_ex_ready=1.
- Back-pressure: with o_id_valid=1 and i_ex_ready=0, o_if_ready=0 and all held outputs are stable except bypassed operands.
- Simultaneous transfer out and transfer in: new instruction captured; o_id_valid stays 1 with no bubble.
- Writeback to x0 is never bypassed or refreshed.
- The register file updates at the same edge at which i_wb_* is sampled. The capture-path bypass covers that edge.
- No combinational path from i_ex_ready to o_id_* data. The only combinational path is i_ex_ready→o_if_ready.

## Test plan
- Reset, then feed `addi x1,x0,5` (0x00500093) at pc=0x100 with i_ex_ready=1:
  - Next cycle o_id_valid=1, rd=1, rs1=0, imm=5, rs1_value=0, illegal=0.
  - Next cycle o_id_valid=0 if no new beat.
- Capture bypass:
  - i_rf_value[3]=0x11.
  - In the capture cycle i_wb_valid=1, i_wb_rd=3, i_wb_value=0x22.
  - Instruction `add x4,x3,x3` (0x00318233) → held rs1_value=rs2_value=0x22.
- Stall refresh:
  - Hold `sw x5,-4(x2)` (0xFE512E23) with i_ex_ready=0 for 3 cycles.
  - Writeback x5=0xDEAD in cycle 2 → rs2_value reads 0xDEAD from cycle 2 on; imm=0xFFFFFFFC; o_if_ready=0 throughout.
- Immediates:
  - `beq` 0xFE000EE3 → imm=-4.
  - `jal` 0x0080006F → imm=8.
  - `lui` 0x12345037 → imm=0x12345000.
  - opcode 0x7F → illegal=1, imm=0.
- Back-to-back: 4 consecutive beats with i_ex_ready=1 → 4 consecutive o_id_valid cycles, in order, no bubbles.
- Flush and async reset:
  - While holding a stalled instruction, assert i_flush with i_if_valid=1 → o_if_ready=1; o_id_valid=0 next cycle; beat dropped.
  - Separately, asserting i_rst_n=0 mid-stall → o_id_valid=0 without a clock edge.
